// File: rtl/ide_autoconfig_pkg.sv
// Shared definitions for the IDE board AUTOCONFIG responder: FSM state
// encoding, configuration register byte offsets and the config-space page.
package ide_autoconfig_pkg;

    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_CONF   = 2'd1,
        ST_SHUTUP = 2'd2
    } state_e;

    // Zorro II configuration space lives in the $E8xxxx page
    localparam logic [7:0] CFG_PAGE = 8'hE8;

    // Byte offsets within the config page (ADDR[6:1] with A0 appended)
    localparam logic [6:0] OFF_TYPE    = 7'h00;
    localparam logic [6:0] OFF_PROD    = 7'h04;
    localparam logic [6:0] OFF_MANUF   = 7'h10;
    localparam logic [6:0] OFF_SERIAL  = 7'h18;
    localparam logic [6:0] OFF_ROMVEC  = 7'h28;
    localparam logic [6:0] OFF_BASE_HI = 7'h48;
    localparam logic [6:0] OFF_BASE_LO = 7'h4A;
    localparam logic [6:0] OFF_SHUTUP  = 7'h4C;

    // Every register except er_Type is presented to the bus inverted
    function automatic logic [3:0] inv_nib(input logic [3:0] n);
        return ~n;
    endfunction

endpackage

// File: rtl/ide_autoconfig_rom.sv
// Combinational offset -> nibble lookup for the AUTOCONFIG register image.
// er_Type is served as-is; all other fields are inverted, high nibble first.
// Unimplemented offsets read as inverted zero (4'hF).
module ide_autoconfig_rom
    import ide_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUF_ID   = 16'h07DB,
    parameter logic [7:0]  PROD_ID    = 8'h05,
    parameter logic [31:0] SERIAL     = 32'h00000001,
    parameter logic [15:0] ROM_VECTOR = 16'h4000,
    parameter logic [7:0]  ER_TYPE    = 8'hD1
) (
    input  logic [6:0] offset,
    output logic [3:0] nibble
);

    // Register image lookup; the serial and ROM-vector slots carry the
    // most significant nibbles of their fields
    always_comb begin
        nibble = 4'hF;
        case (offset)
            OFF_TYPE:            nibble = ER_TYPE[7:4];
            OFF_TYPE   + 7'd2:   nibble = ER_TYPE[3:0];
            OFF_PROD:            nibble = inv_nib(PROD_ID[7:4]);
            OFF_PROD   + 7'd2:   nibble = inv_nib(PROD_ID[3:0]);
            OFF_MANUF:           nibble = inv_nib(MANUF_ID[15:12]);
            OFF_MANUF  + 7'd2:   nibble = inv_nib(MANUF_ID[11:8]);
            OFF_MANUF  + 7'd4:   nibble = inv_nib(MANUF_ID[7:4]);
            OFF_MANUF  + 7'd6:   nibble = inv_nib(MANUF_ID[3:0]);
            OFF_SERIAL:          nibble = inv_nib(SERIAL[31:28]);
            OFF_SERIAL + 7'd2:   nibble = inv_nib(SERIAL[27:24]);
            OFF_SERIAL + 7'd4:   nibble = inv_nib(SERIAL[23:20]);
            OFF_SERIAL + 7'd6:   nibble = inv_nib(SERIAL[19:16]);
            OFF_ROMVEC:          nibble = inv_nib(ROM_VECTOR[15:12]);
            OFF_ROMVEC + 7'd2:   nibble = inv_nib(ROM_VECTOR[11:8]);
            default:             nibble = 4'hF;
        endcase
    end

endmodule

// File: rtl/ide_autoconfig.sv
// Zorro II AUTOCONFIG responder for the IDE board. Serves the config
// nibbles at $E8xxxx, takes the assigned 64K base (or shut-up), drives
// CFGOUT_n and, once configured, flags CPU cycles in the assigned window.
module ide_autoconfig
    import ide_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUF_ID   = 16'h07DB,
    parameter logic [7:0]  PROD_ID    = 8'h05,
    parameter logic [31:0] SERIAL     = 32'h00000001,
    parameter logic [15:0] ROM_VECTOR = 16'h4000,
    parameter logic [7:0]  ER_TYPE    = 8'hD1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [23:1] ADDR,
    input  logic [3:0]  DIN,
    input  logic        RW,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        CFGIN_n,
    output logic [3:0]  DOUT,
    output logic        DOE,
    output logic        DTACK,
    output logic        CFGOUT_n,
    output logic        ide_access
);

    state_e      state_q, state_d;
    logic [7:0]  base_q, base_d;
    logic [3:0]  lo_nib_q, lo_nib_d;
    logic [3:0]  dout_q, dout_d;
    logic        cfgout_n_q, cfgout_n_d;
    logic        dtack_q, dtack_d;
    logic        write_done_q, write_done_d;
    logic        armed_q, armed_d;

    logic [6:0]  offset;
    logic [3:0]  rom_nib;
    logic        cfg_sel;
    logic        wr_en;
    logic        wr_base_hi;
    logic        wr_base_lo;
    logic        wr_shutup;
    logic        cyc_clr_n;
    logic        unused_addr;

    assign offset      = {ADDR[6:1], 1'b0};
    assign unused_addr = ^ADDR[15:7];

    // Per-bus-cycle flops are cleared whenever the strobe is released
    assign cyc_clr_n = RESET_n & ~AS_n;

    ide_autoconfig_rom #(
        .MANUF_ID   (MANUF_ID),
        .PROD_ID    (PROD_ID),
        .SERIAL     (SERIAL),
        .ROM_VECTOR (ROM_VECTOR),
        .ER_TYPE    (ER_TYPE)
    ) u_rom (
        .offset (offset),
        .nibble (rom_nib)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state_q <= ST_UNCONF;
        else          state_q <= state_d;
    end

    // FSM next state: leave UNCONF on a base-high or shut-up write, then stay
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCONF: begin
                if (wr_base_hi)     state_d = ST_CONF;
                else if (wr_shutup) state_d = ST_SHUTUP;
            end
            default:   state_d = state_q;
        endcase
    end

    // FSM outputs: config-space select, bus drive enable and window decode
    always_comb begin
        cfg_sel    = (state_q == ST_UNCONF) && !CFGIN_n && !AS_n &&
                     (ADDR[23:16] == CFG_PAGE);
        DOE        = cfg_sel && RW;
        ide_access = (state_q == ST_CONF) && !AS_n && (ADDR[23:16] == base_q);
    end

    // Write qualification: one write per bus cycle, only from an armed cycle
    always_comb begin
        wr_en      = cfg_sel && armed_q && !RW && (!UDS_n || !LDS_n) && !write_done_q;
        wr_base_hi = wr_en && (offset == OFF_BASE_HI);
        wr_base_lo = wr_en && (offset == OFF_BASE_LO);
        wr_shutup  = wr_en && (offset == OFF_SHUTUP);
    end

    // Next values for the configuration registers, read data and cycle flags.
    // armed_q blocks a cycle that was already in flight across a reset.
    always_comb begin
        lo_nib_d     = wr_base_lo ? DIN : lo_nib_q;
        base_d       = wr_base_hi ? {DIN, lo_nib_q} : base_q;
        cfgout_n_d   = cfgout_n_q && !(wr_base_hi || wr_shutup);
        dout_d       = rom_nib;
        armed_d      = armed_q || AS_n;
        dtack_d      = dtack_q || (cfg_sel && armed_q);
        write_done_d = write_done_q || wr_en;
    end

    // Configuration registers and registered read data
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            base_q     <= 8'h00;
            lo_nib_q   <= 4'h0;
            dout_q     <= 4'h0;
            cfgout_n_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            lo_nib_q   <= lo_nib_d;
            dout_q     <= dout_d;
            cfgout_n_q <= cfgout_n_d;
            armed_q    <= armed_d;
        end
    end

    // Per-cycle acknowledge and write-once flags, dropped as AS_n rises
    always_ff @(posedge CLK or negedge cyc_clr_n) begin
        if (!cyc_clr_n) begin
            dtack_q      <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            dtack_q      <= dtack_d;
            write_done_q <= write_done_d;
        end
    end

    assign DOUT     = dout_q;
    assign DTACK    = dtack_q;
    assign CFGOUT_n = cfgout_n_q;

endmodule

// File: tb/tb_ide_autoconfig.sv
// Self-checking bench for ide_autoconfig: read data is scoreboarded at
// stimulus time and compared when DTACK arrives.
module tb_ide_autoconfig;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic [23:1] ADDR;
    logic [3:0]  DIN;
    logic        RW, AS_n, UDS_n, LDS_n, CFGIN_n;
    logic [3:0]  DOUT;
    logic        DOE, DTACK, CFGOUT_n, ide_access;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sb_q[$];

    ide_autoconfig dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .ADDR       (ADDR),
        .DIN        (DIN),
        .RW         (RW),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .LDS_n      (LDS_n),
        .CFGIN_n    (CFGIN_n),
        .DOUT       (DOUT),
        .DOE        (DOE),
        .DTACK      (DTACK),
        .CFGOUT_n   (CFGOUT_n),
        .ide_access (ide_access)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        RESET_n = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // Wait (bounded) for the acknowledge of the cycle just started
    task automatic wait_ack(input logic ack, input logic is_read, input string tag);
        int n;
        logic [3:0] exp_nib;
        n = 0;
        if (ack) begin
            while (!DTACK && n < 6) begin
                @(negedge CLK);
                n++;
            end
            if (is_read) exp_nib = (sb_q.size() > 0) ? sb_q.pop_front() : 4'h0;
            else         exp_nib = 4'h0;
            if (DTACK) begin
                check({tag, "_lat"}, n, 1);
                if (is_read) check(tag, DOUT, exp_nib);
            end else begin
                check({tag, "_timeout"}, DTACK, 1);
            end
        end else begin
            repeat (3) @(negedge CLK);
            check({tag, "_nack"}, DTACK, 0);
        end
    endtask

    task automatic end_cycle(input string tag);
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        #1 check({tag, "_dtclr"}, DTACK, 0);
    endtask

    task automatic bus_read(input logic [23:0] a, input logic ack, input logic [3:0] nib,
                            input string tag);
        @(negedge CLK);
        ADDR = a[23:1]; RW = 1'b1;
        @(negedge CLK);
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
        if (ack) sb_q.push_back(nib);
        #1 check({tag, "_doe"}, DOE, ack);
        wait_ack(ack, 1'b1, tag);
        end_cycle(tag);
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [3:0] nib, input logic ack,
                             input string tag);
        @(negedge CLK);
        ADDR = a[23:1]; RW = 1'b0; DIN = nib;
        @(negedge CLK);
        AS_n = 1'b0; UDS_n = 1'b0;
        #1 check({tag, "_doe"}, DOE, 0);
        wait_ack(ack, 1'b0, tag);
        end_cycle(tag);
    endtask

    task automatic probe(input logic [23:0] a, input logic exp, input string tag);
        @(negedge CLK);
        ADDR = a[23:1]; RW = 1'b1; AS_n = 1'b0;
        #1 check(tag, ide_access, exp);
        @(negedge CLK);
        AS_n = 1'b1;
        #1 check({tag, "_idle"}, ide_access, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_n = 1'b0; CFGIN_n = 1'b0; ADDR = '0; DIN = 4'h0;
        RW = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_dout",   DOUT, 4'h0);
        check("rst_dtack",  DTACK, 0);
        check("rst_cfgout", CFGOUT_n, 1);
        check("rst_doe",    DOE, 0);
        check("rst_ide",    ide_access, 0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Register image reads
        bus_read(24'hE80000, 1'b1, 4'hD, "rd_type_hi");
        bus_read(24'hE80002, 1'b1, 4'h1, "rd_type_lo");
        bus_read(24'hE80004, 1'b1, 4'hF, "rd_prod_hi");
        bus_read(24'hE80006, 1'b1, 4'hA, "rd_prod_lo");
        bus_read(24'hE80010, 1'b1, 4'hF, "rd_man0");
        bus_read(24'hE80012, 1'b1, 4'h8, "rd_man1");
        bus_read(24'hE80014, 1'b1, 4'h2, "rd_man2");
        bus_read(24'hE80016, 1'b1, 4'h4, "rd_man3");
        bus_read(24'hE80028, 1'b1, 4'hB, "rd_rom_hi");
        bus_read(24'hE80030, 1'b1, 4'hF, "rd_other");
        bus_read(24'hE90000, 1'b0, 4'h0, "rd_offpage");

        // Chain input high: no response at all
        CFGIN_n = 1'b1;
        bus_read(24'hE80000, 1'b0, 4'h0, "cfgin_rd");
        bus_write(24'hE80048, 4'hE, 1'b0, "cfgin_wr");
        @(negedge CLK);
        check("cfgin_cfgout", CFGOUT_n, 1);
        probe(24'hE00000, 1'b0, "cfgin_ide");
        CFGIN_n = 1'b0;

        // Held write at $4A: second DIN value must not be taken
        @(negedge CLK);
        ADDR = 23'(24'hE8004A >> 1); RW = 1'b0; DIN = 4'h3;
        @(negedge CLK);
        AS_n = 1'b0; LDS_n = 1'b0;
        repeat (2) @(negedge CLK);
        DIN = 4'h7;
        repeat (2) @(negedge CLK);
        check("hold4a_ack", DTACK, 1);
        end_cycle("hold4a");
        bus_write(24'hE80048, 4'hE, 1'b1, "wr_base_e3");
        @(negedge CLK);
        check("e3_cfgout", CFGOUT_n, 0);
        probe(24'hE30000, 1'b1, "e3_in");
        probe(24'hE70000, 1'b0, "e3_out");

        // Normal configuration: base $E9
        do_reset();
        check("rst2_cfgout", CFGOUT_n, 1);
        bus_write(24'hE8004A, 4'h9, 1'b1, "wr_lo9");
        bus_write(24'hE80048, 4'hE, 1'b1, "wr_hiE");
        @(negedge CLK);
        check("conf_cfgout", CFGOUT_n, 0);
        probe(24'hE91000, 1'b1, "conf_in");
        probe(24'hEA0000, 1'b0, "conf_out");
        bus_read(24'hE80000, 1'b0, 4'h0, "conf_rd");
        bus_write(24'hE8004A, 4'h1, 1'b0, "conf_wr");
        probe(24'hE90000, 1'b1, "conf_in2");

        // Base-high write with no preceding low-nibble write
        do_reset();
        bus_write(24'hE80048, 4'h2, 1'b1, "wr_hi2");
        probe(24'h200000, 1'b1, "hi2_in");
        probe(24'h290000, 1'b0, "hi2_out");

        // Shut-up: base stays $00 but nothing ever decodes
        do_reset();
        bus_write(24'hE8004C, 4'h0, 1'b1, "wr_shut");
        @(negedge CLK);
        check("shut_cfgout", CFGOUT_n, 0);
        bus_read(24'hE80000, 1'b0, 4'h0, "shut_rd");
        probe(24'h000000, 1'b0, "shut_ide00");
        probe(24'hE80000, 1'b0, "shut_ideE8");
        probe(24'h200000, 1'b0, "shut_ide20");

        // Reset pulsed in the middle of a held write cycle
        do_reset();
        @(negedge CLK);
        ADDR = 23'(24'hE80048 >> 1); RW = 1'b0; DIN = 4'h5;
        @(negedge CLK);
        AS_n = 1'b0; UDS_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("mid_ack", DTACK, 1);
        check("mid_cfgout", CFGOUT_n, 0);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_dtack",  DTACK, 0);
        check("mid_rst_cfgout", CFGOUT_n, 1);
        check("mid_rst_dout",   DOUT, 4'h0);
        check("mid_rst_ide",    ide_access, 0);
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("mid_nack",    DTACK, 0);
        check("mid_nowrite", CFGOUT_n, 1);
        end_cycle("mid");
        @(negedge CLK);
        bus_read(24'hE80002, 1'b1, 4'h1, "post_rd");

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
